cl_tx_arbiter: RTL and testbench
================================

Name: cl_tx_arbiter

Overview:
Shares one Client-IF TX segment channel among N_PORTS upstream AXI-to-segment bridges, for example one per VC or per IP. Arbitration is packet-atomic: a grant is held from the first segment of a frame until its EOP handshake. Port selection is weighted round-robin: a port may take up to port_weight consecutive frames before the pointer moves on. The block sits between the bridge TX instances and the protocol layer, and adds frame-integrity checks and telemetry.

Parameters:
N_PORTS, 4, number of requesting segment streams (2..16)
IF_W, 64, segment data width (multiple of 8)
TUSER_W, 16, sideband metadata width
WEIGHT_W, 4, width of each per-port weight field

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
s_data  in  N_PORTS*IF_W  per-port segment data; port p occupies [p*IF_W +: IF_W]
s_keep  in  N_PORTS*IF_W/8  per-port byte enables
s_user  in  N_PORTS*TUSER_W  per-port metadata
s_valid/s_sop/s_eop  in  N_PORTS  per-port valid, start-of-packet, end-of-packet
s_ready  out  N_PORTS  per-port ready
m_data/m_keep/m_user  out  IF_W / IF_W/8 / TUSER_W  muxed segment output
m_valid/m_sop/m_eop  out  1 each  muxed segment handshake and framing
m_ready  in  1  downstream ready
arb_enable  in  1  global enable for new grants
port_en  in  N_PORTS  per-port eligibility mask
port_weight  in  N_PORTS*WEIGHT_W  burst weight per port; a value of 0 is treated as 1
max_pkt_segs  in  16  watchdog limit in segments per frame; 0 disables the watchdog
cur_grant  out  $clog2(N_PORTS)  currently or last granted port
busy  out  1  asserted while in LOCK
stat_frames  out  32  completed frames (EOP handshakes), wraps
stat_idle_bubbles  out  32  IDLE cycles in which at least one eligible port had valid, wraps
ev_err_nosop  out  1  1-cycle pulse: first segment of a grant lacked SOP
ev_err_sop_mid  out  1  1-cycle pulse: SOP seen after the first segment of a frame
ev_err_watchdog  out  1  1-cycle pulse: frame forcibly released by the watchdog

Behaviour:
- Reset values: state=IDLE; cur_grant=0; last_grant=N_PORTS-1, so port 0 wins first; burst_cnt=0; seg_cnt=0; first_seg=1; all counters 0; all ev_* 0.
- Port p is eligible when s_valid[p] && port_en[p] && arb_enable.
- State machine has two states, IDLE and LOCK.
- IDLE:
  - s_ready=0 on every port; m_valid=0; m_data, m_keep, m_user, m_sop, m_eop all driven 0.
  - If any port is eligible, pick a winner:
    - last_grant wins if it is eligible and burst_cnt < eff_weight(last_grant).
    - Otherwise the winner is the first eligible port scanning from last_grant+1, wrapping modulo N_PORTS.
  - Register cur_grant=winner and go to LOCK next cycle.
  - burst_cnt = burst_cnt+1 if winner==last_grant, else 1.
  - Set seg_cnt=0 and first_seg=1.
  - If at least one port is eligible, stat_idle_bubbles increments. This counts the fixed 1-cycle arbitration bubble per frame, including the cycle in which a winner is selected.
- LOCK (g=cur_grant):
  - m_* = s_*[g] combinationally; s_ready[g]=m_ready; all other s_ready=0. No added latency.
  - A handshake is m_valid && m_ready. On each handshake, seg_cnt++ and first_seg<=0.
  - Handshake with first_seg=1 and s_sop[g]=0 -> pulse ev_err_nosop; the segment still passes.
  - Handshake with first_seg=0 and s_sop[g]=1 -> pulse ev_err_sop_mid; the segment still passes.
  - Handshake with m_eop=1 -> stat_frames++, last_grant<=g, go to IDLE.
  - Watchdog: a handshake without EOP where max_pkt_segs!=0 and seg_cnt+1 == max_pkt_segs -> pulse ev_err_watchdog, last_grant<=g, burst_cnt<=eff_weight(g), go to IDLE. Setting burst_cnt this way forces the pointer to move on. The remainder of that frame later arrives without SOP and flags ev_err_nosop.
- Deasserting arb_enable or port_en[g] during LOCK does not truncate the frame. The current frame completes; only new grants are gated.
- Reset asserted mid-frame: everything returns to reset values immediately; no event is raised.
- Simultaneous EOP and watchdog limit on the same handshake: EOP takes precedence; no watchdog event.
- stat_frames and stat_idle_bubbles wrap modulo 2^32.
- busy = (state==LOCK).
- All ev_* are registered, so each pulses one cycle after the triggering handshake.

Decomposition:
- Package cl_arb_pkg holds:
  - arb_state_e {IDLE, LOCK}
  - typedef port_idx_t, logic [$clog2(N_PORTS)-1:0]
  - function eff_weight, which maps 0 to 1
- Sub-module rr_pick: combinational find-first-set over a request vector, starting at ptr+1 and wrapping. Outputs are gnt_idx and gnt_any. It is reused later by the RX demux.

Test Plan:
1. Reset, then port 0 alone sends a 3-segment frame with m_ready=1. Required: grant in the cycle after valid; 3 segments out with SOP on the 1st and EOP on the 3rd; stat_frames=1; stat_idle_bubbles=1.
2. All 4 ports continuously send 1-segment frames, all weights=1. Required: grant order 0,1,2,3,0,...; one bubble between frames; no ev_*.
3. Weights {3,1,1,1}, all ports requesting. Required: order 0,0,0,1,2,3,0,0,0; a weight of 0 on port 1 behaves as 1.
4. Port 1 in LOCK; m_ready toggles 1010 for 8 cycles; port 2 asserts valid mid-frame. Required: s_ready[2]=0 until port 1's EOP; no segment loss; output data matches input order.
5. max_pkt_segs=4; port 0 sends 6 segments with EOP on the 6th. Required: ev_err_watchdog one cycle after the 4th handshake; port 1 is granted next if it is requesting; on port 0's later re-grant its 5th segment raises ev_err_nosop.
6. Port 2 sends a frame with SOP also set on its 2nd segment; separately, arb_enable is dropped mid-frame. Required: ev_err_sop_mid pulses once; the frame completes, then no new grants are issued while arb_enable=0.

Source files
------------

// File: rtl/cl_tx_arbiter_pkg.sv
// Shared types and helpers for the Client-IF TX segment arbiter.
// Also reused by the RX demux for its port pointer.
package cl_arb_pkg;

  localparam int DEF_N_PORTS  = 4;
  localparam int DEF_IF_W     = 64;
  localparam int DEF_TUSER_W  = 16;
  localparam int DEF_WEIGHT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  typedef logic [$clog2(DEF_N_PORTS)-1:0] port_idx_t;

  function automatic logic [DEF_WEIGHT_W-1:0] eff_weight(
    input logic [DEF_WEIGHT_W-1:0] w
  );
    return (w == '0) ? DEF_WEIGHT_W'(1) : w;
  endfunction

endpackage

// File: rtl/cl_tx_arbiter_if.sv
// Segment bus between the bridge TX ports, the arbiter and the protocol layer.
// master = upstream sources plus downstream sink, slave = the arbiter.
interface cl_tx_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int IF_W    = 64,
  parameter int TUSER_W = 16
);
  logic [N_PORTS*IF_W-1:0]     s_data;
  logic [N_PORTS*IF_W/8-1:0]   s_keep;
  logic [N_PORTS*TUSER_W-1:0]  s_user;
  logic [N_PORTS-1:0]          s_valid;
  logic [N_PORTS-1:0]          s_sop;
  logic [N_PORTS-1:0]          s_eop;
  logic [N_PORTS-1:0]          s_ready;
  logic [IF_W-1:0]             m_data;
  logic [IF_W/8-1:0]           m_keep;
  logic [TUSER_W-1:0]          m_user;
  logic                        m_valid;
  logic                        m_sop;
  logic                        m_eop;
  logic                        m_ready;

  modport master (
    output s_data, s_keep, s_user,
    output s_valid, s_sop, s_eop,
    input  s_ready,
    input  m_data, m_keep, m_user,
    input  m_valid, m_sop, m_eop,
    output m_ready
  );

  modport slave (
    input  s_data, s_keep, s_user,
    input  s_valid, s_sop, s_eop,
    output s_ready,
    output m_data, m_keep, m_user,
    output m_valid, m_sop, m_eop,
    input  m_ready
  );
endinterface

// File: rtl/cl_tx_arbiter_rr_pick.sv
// Round-robin find-first-set: first requester after ptr, wrapping.
// ptr itself is considered last.
module rr_pick #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_any
);

  int q;

  // Scan from farthest to nearest so the nearest hit is the one kept.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    q       = 0;
    for (int k = N; k >= 1; k--) begin
      q = (int'(ptr) + k) % N;
      if (req[q]) begin
        gnt_idx = W'(q);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cl_tx_arbiter.sv
// Packet-atomic weighted round-robin arbiter muxing N segment streams
// onto one Client-IF TX channel, with frame checks and telemetry.
module cl_tx_arbiter
  import cl_arb_pkg::*;
#(
  parameter  int N_PORTS  = DEF_N_PORTS,
  parameter  int IF_W     = DEF_IF_W,
  parameter  int TUSER_W  = DEF_TUSER_W,
  parameter  int WEIGHT_W = DEF_WEIGHT_W,
  localparam int PW       = $clog2(N_PORTS)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  cl_tx_arbiter_if.slave               bus,
  input  logic                         arb_enable,
  input  logic [N_PORTS-1:0]           port_en,
  input  logic [N_PORTS*WEIGHT_W-1:0]  port_weight,
  input  logic [15:0]                  max_pkt_segs,
  output logic [PW-1:0]                cur_grant,
  output logic                         busy,
  output logic [31:0]                  stat_frames,
  output logic [31:0]                  stat_idle_bubbles,
  output logic                         ev_err_nosop,
  output logic                         ev_err_sop_mid,
  output logic                         ev_err_watchdog
);

  arb_state_e          r_state;
  logic [PW-1:0]       r_grant;
  logic [PW-1:0]       r_last;
  logic [WEIGHT_W-1:0] r_burst;
  logic [15:0]         r_seg;
  logic                r_first;
  logic [31:0]         r_frames;
  logic [31:0]         r_bubbles;
  logic                r_ev_nosop;
  logic                r_ev_sopmid;
  logic                r_ev_wd;

  logic [N_PORTS-1:0]  w_elig;
  logic [PW-1:0]       w_rr_idx;
  logic [PW-1:0]       w_win;
  logic                w_any;
  logic [WEIGHT_W-1:0] w_last_w;
  logic [WEIGHT_W-1:0] w_cur_w;
  logic [WEIGHT_W-1:0] w_burst_inc;
  logic                w_lock;
  logic                w_hs;
  logic                w_sop;
  logic                w_eop;
  logic [15:0]         w_seg_nxt;
  logic                w_wd_hit;

  assign w_elig = bus.s_valid & port_en & {N_PORTS{arb_enable}};

  rr_pick #(.N(N_PORTS)) u_pick (
    .req     (w_elig),
    .ptr     (r_last),
    .gnt_idx (w_rr_idx),
    .gnt_any (w_any)
  );

  assign w_last_w = eff_weight(
    port_weight[int'(r_last)*WEIGHT_W +: WEIGHT_W]);
  assign w_cur_w  = eff_weight(
    port_weight[int'(r_grant)*WEIGHT_W +: WEIGHT_W]);

  // Last winner keeps the channel while its burst allowance lasts.
  assign w_win = (w_elig[r_last] && (r_burst < w_last_w))
               ? r_last : w_rr_idx;

  // Saturate: a lone requester may win repeatedly past its weight.
  assign w_burst_inc = (r_burst == '1) ? r_burst
                     : r_burst + WEIGHT_W'(1);

  assign w_lock    = (r_state == LOCK);
  assign w_sop     = bus.s_sop[r_grant];
  assign w_eop     = bus.s_eop[r_grant];
  assign w_hs      = w_lock && bus.s_valid[r_grant] && bus.m_ready;
  assign w_seg_nxt = r_seg + 16'd1;
  assign w_wd_hit  = (max_pkt_segs != 16'd0)
                  && (w_seg_nxt == max_pkt_segs);

  always_comb begin
    bus.m_data  = '0;
    bus.m_keep  = '0;
    bus.m_user  = '0;
    bus.m_valid = 1'b0;
    bus.m_sop   = 1'b0;
    bus.m_eop   = 1'b0;
    bus.s_ready = '0;
    if (w_lock) begin
      bus.m_data  = bus.s_data[int'(r_grant)*IF_W +: IF_W];
      bus.m_keep  = bus.s_keep[int'(r_grant)*(IF_W/8) +: IF_W/8];
      bus.m_user  = bus.s_user[int'(r_grant)*TUSER_W +: TUSER_W];
      bus.m_valid = bus.s_valid[r_grant];
      bus.m_sop   = w_sop;
      bus.m_eop   = w_eop;
      bus.s_ready[r_grant] = bus.m_ready;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_last      <= PW'(N_PORTS - 1);
      r_burst     <= '0;
      r_seg       <= '0;
      r_first     <= 1'b1;
      r_frames    <= '0;
      r_bubbles   <= '0;
      r_ev_nosop  <= 1'b0;
      r_ev_sopmid <= 1'b0;
      r_ev_wd     <= 1'b0;
    end else begin
      r_ev_nosop  <= 1'b0;
      r_ev_sopmid <= 1'b0;
      r_ev_wd     <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_bubbles <= r_bubbles + 32'd1;
            r_grant   <= w_win;
            r_burst   <= (w_win == r_last) ? w_burst_inc
                                           : WEIGHT_W'(1);
            r_seg     <= '0;
            r_first   <= 1'b1;
            r_state   <= LOCK;
          end
        end
        LOCK: begin
          if (w_hs) begin
            r_seg       <= w_seg_nxt;
            r_first     <= 1'b0;
            r_ev_nosop  <= r_first & ~w_sop;
            r_ev_sopmid <= ~r_first & w_sop;
            if (w_eop) begin
              r_frames <= r_frames + 32'd1;
              r_last   <= r_grant;
              r_state  <= IDLE;
            end else if (w_wd_hit) begin
              // Exhaust the burst so the pointer moves past this port.
              r_ev_wd  <= 1'b1;
              r_last   <= r_grant;
              r_burst  <= w_cur_w;
              r_state  <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cur_grant         = r_grant;
  assign busy              = w_lock;
  assign stat_frames       = r_frames;
  assign stat_idle_bubbles = r_bubbles;
  assign ev_err_nosop      = r_ev_nosop;
  assign ev_err_sop_mid    = r_ev_sopmid;
  assign ev_err_watchdog   = r_ev_wd;

endmodule

// File: tb/tb_cl_tx_arbiter.sv
// Scoreboard bench for cl_tx_arbiter: per-port frame queues, a
// frame-level reference model and a decoupled output monitor.
module tb_cl_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int UW = 16;

  typedef struct packed {
    logic [DW-1:0]   d;
    logic [DW/8-1:0] k;
    logic [UW-1:0]   u;
    logic            sop;
    logic            eop;
  } seg_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arb_enable;
  logic [N-1:0]  port_en;
  logic [N*4-1:0] port_weight;
  logic [15:0]   max_pkt_segs;
  logic [1:0]    cur_grant;
  logic          busy;
  logic [31:0]   stat_frames;
  logic [31:0]   stat_idle_bubbles;
  logic          ev_err_nosop;
  logic          ev_err_sop_mid;
  logic          ev_err_watchdog;

  cl_tx_arbiter_if #(.N_PORTS(N), .IF_W(DW), .TUSER_W(UW)) bus ();

  cl_tx_arbiter #(.N_PORTS(N), .IF_W(DW), .TUSER_W(UW), .WEIGHT_W(4))
  dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .bus               (bus),
    .arb_enable        (arb_enable),
    .port_en           (port_en),
    .port_weight       (port_weight),
    .max_pkt_segs      (max_pkt_segs),
    .cur_grant         (cur_grant),
    .busy              (busy),
    .stat_frames       (stat_frames),
    .stat_idle_bubbles (stat_idle_bubbles),
    .ev_err_nosop      (ev_err_nosop),
    .ev_err_sop_mid    (ev_err_sop_mid),
    .ev_err_watchdog   (ev_err_watchdog)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  // Stimulus state
  seg_t     pq[N][$];
  int       seq = 0;
  int       rdy_pct = 100;
  int       gap_pct = 0;
  bit       rdy_toggle = 1'b0;
  bit [N-1:0] hs_p = '0;
  bit       run = 1'b0;

  // Reference model state
  bit       mlock = 1'b0;
  int       mgrant = 0;
  int       mlast = N - 1;
  int       mburst = 0;
  int       mseg = 0;
  bit       mfirst = 1'b1;
  int unsigned mframes = 0;
  int unsigned mbubbles = 0;
  logic [1:0]   exp_grant = '0;
  logic         exp_busy = 1'b0;
  logic [N-1:0] exp_sready = '0;
  seg_t     exp_q[$];
  logic [2:0] ev_q[$];

  function automatic int effw(input int p);
    int w;
    w = int'(port_weight[4*p +: 4]);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic bit all_empty();
    for (int p = 0; p < N; p++)
      if (pq[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic gen_frame(input int p, input int len, input int err);
    seg_t s;
    for (int i = 0; i < len; i++) begin
      s.d   = {8'(p), 24'(seq), 32'($urandom)};
      s.k   = 8'($urandom);
      s.u   = 16'($urandom);
      s.sop = (i == 0 && err != 1) || (i == 1 && err == 2);
      s.eop = (i == len - 1);
      seq++;
      pq[p].push_back(s);
    end
  endtask

  // Source and sink driver
  always @(posedge clk) begin
    #1;
    for (int p = 0; p < N; p++)
      if (hs_p[p] && pq[p].size() > 0) void'(pq[p].pop_front());
    hs_p = '0;
    for (int p = 0; p < N; p++) begin
      seg_t s;
      s = '0;
      bus.s_valid[p] = 1'b0;
      if (pq[p].size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
        s = pq[p][0];
        bus.s_valid[p] = 1'b1;
      end
      bus.s_data[p*DW +: DW]     = s.d;
      bus.s_keep[p*DW/8 +: DW/8] = s.k;
      bus.s_user[p*UW +: UW]     = s.u;
      bus.s_sop[p]               = s.sop;
      bus.s_eop[p]               = s.eop;
    end
    if (rdy_toggle) bus.m_ready = ~bus.m_ready;
    else bus.m_ready = (int'($urandom_range(99)) < rdy_pct);
  end

  // Reference model: predicts the next clock edge from spec rules
  always @(negedge clk) begin
    if (run) begin
      logic [2:0] ev;
      logic [N-1:0] elig;
      int win;
      bit found;
      ev = '0;
      exp_busy   = mlock;
      exp_grant  = 2'(mgrant);
      exp_sready = '0;
      if (mlock) exp_sready[mgrant] = bus.m_ready;
      if (!mlock) begin
        elig = bus.s_valid & port_en & {N{arb_enable}};
        if (elig != '0) begin
          mbubbles++;
          found = 1'b0;
          win = 0;
          if (elig[mlast] && mburst < effw(mlast)) begin
            win = mlast;
            found = 1'b1;
          end
          for (int k = 1; k <= N; k++) begin
            if (!found && elig[(mlast + k) % N]) begin
              win = (mlast + k) % N;
              found = 1'b1;
            end
          end
          mburst = (win == mlast) ? mburst + 1 : 1;
          mgrant = win;
          mlock  = 1'b1;
          mseg   = 0;
          mfirst = 1'b1;
        end
      end else if (bus.s_valid[mgrant] && bus.m_ready) begin
        seg_t s;
        s = pq[mgrant][0];
        exp_q.push_back(s);
        if (mfirst && !s.sop) ev[2] = 1'b1;
        if (!mfirst && s.sop) ev[1] = 1'b1;
        mseg++;
        mfirst = 1'b0;
        if (s.eop) begin
          mframes++;
          mlast = mgrant;
          mlock = 1'b0;
        end else if (max_pkt_segs != 0 && mseg == int'(max_pkt_segs)) begin
          ev[0]  = 1'b1;
          mlast  = mgrant;
          mburst = effw(mgrant);
          mlock  = 1'b0;
        end
      end
      ev_q.push_back(ev);
    end
  end

  // Monitor: compares what the DUT presents against the scoreboard
  always @(negedge clk) begin
    #1;
    if (run) begin
      logic [2:0] e;
      seg_t s;
      for (int p = 0; p < N; p++)
        hs_p[p] = bus.s_valid[p] & bus.s_ready[p];
      chk("busy", busy, exp_busy);
      chk("cur_grant", cur_grant, exp_grant);
      chk("s_ready", bus.s_ready, exp_sready);
      e = (ev_q.size() > 0) ? ev_q.pop_front() : 3'b000;
      chk("ev", {ev_err_nosop, ev_err_sop_mid, ev_err_watchdog}, e);
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL hs_unexpected: got data %0h expected none",
                   bus.m_data);
        end else begin
          s = exp_q.pop_front();
          chk("seg", {bus.m_data, bus.m_keep, bus.m_user,
                      bus.m_sop, bus.m_eop}, s);
        end
      end
    end
  end

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (c < budget && !(all_empty() && !mlock && exp_q.size() == 0)) begin
      @(negedge clk);
      #2;
      c++;
    end
    if (c >= budget) begin
      n_chk++;
      $display("FAIL drain_timeout: got %0d cycles required < %0d",
               c, budget);
    end
    repeat (3) @(negedge clk);
    #2;
    chk("stat_frames", stat_frames, mframes);
    chk("stat_bubbles", stat_idle_bubbles, mbubbles);
  endtask

  task automatic setup();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int mx[5];
    mx = '{0, 0, 3, 4, 5};
    arb_enable   = 1'b1;
    port_en      = '1;
    port_weight  = {4'd1, 4'd1, 4'd1, 4'd1};
    max_pkt_segs = 16'd0;
    bus.m_ready  = 1'b1;
    bus.s_valid  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", cur_grant, 2'd0);
    chk("rst_frames", stat_frames, 32'd0);
    chk("rst_bubbles", stat_idle_bubbles, 32'd0);
    chk("rst_mvalid", bus.m_valid, 1'b0);
    chk("rst_ev", {ev_err_nosop, ev_err_sop_mid, ev_err_watchdog}, 3'b0);
    ev_q.push_back(3'b000);
    @(posedge clk);
    #2;
    rst = 1'b0;
    run = 1'b1;

    // Single 3-segment frame from port 0
    setup();
    gen_frame(0, 3, 0);
    drain(200);
    chk("t1_frames", stat_frames, 32'd1);
    chk("t1_bubbles", stat_idle_bubbles, 32'd1);

    // All ports, 1-segment frames, equal weights
    setup();
    for (int i = 0; i < 3; i++)
      for (int p = 0; p < N; p++) gen_frame(p, 1, 0);
    drain(400);

    // Weights {3,0,1,1}: port 1 weight 0 acts as 1
    setup();
    port_weight = {4'd1, 4'd1, 4'd0, 4'd3};
    for (int i = 0; i < 4; i++)
      for (int p = 0; p < N; p++) gen_frame(p, 1, 0);
    drain(400);

    // Toggling ready mid-frame with a competing requester
    setup();
    port_weight = {4'd1, 4'd1, 4'd1, 4'd1};
    rdy_toggle  = 1'b1;
    gen_frame(1, 4, 0);
    repeat (2) setup();
    gen_frame(2, 2, 0);
    drain(400);
    rdy_toggle = 1'b0;

    // Watchdog split, SOP mid-frame, arb_enable drop mid-frame
    setup();
    max_pkt_segs = 16'd4;
    gen_frame(0, 6, 0);
    gen_frame(1, 2, 0);
    drain(400);
    setup();
    max_pkt_segs = 16'd0;
    gen_frame(2, 5, 2);
    repeat (3) setup();
    arb_enable = 1'b0;
    gen_frame(3, 2, 0);
    repeat (20) setup();
    arb_enable = 1'b1;
    drain(400);

    // Randomized rounds
    for (int r = 0; r < 6; r++) begin
      setup();
      for (int p = 0; p < N; p++)
        port_weight[4*p +: 4] = 4'($urandom_range(0, 4));
      max_pkt_segs = 16'(mx[$urandom_range(0, 4)]);
      rdy_pct = int'($urandom_range(30, 100));
      gap_pct = int'($urandom_range(0, 40));
      for (int c = 0; c < 400; c++) begin
        int p;
        int len;
        int err;
        setup();
        if ($urandom_range(99) < 30) begin
          p   = int'($urandom_range(0, N - 1));
          len = int'($urandom_range(1, 6));
          err = 0;
          if ($urandom_range(99) < 6) err = 1;
          else if (len > 1 && $urandom_range(99) < 6) err = 2;
          if (pq[p].size() < 24) gen_frame(p, len, err);
        end
        if ($urandom_range(99) < 3) port_en = 4'($urandom);
        arb_enable = ($urandom_range(99) < 92);
      end
      setup();
      port_en    = '1;
      arb_enable = 1'b1;
      drain(4000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
